// File: rtl/multiplier_datapath_if.sv
// rtl/multiplier_datapath_if.sv - command/status bundle between shift-add controller and datapath
interface multiplier_datapath_if #(
  parameter int WIDTH = 8
);
  // Operands and commands, driven by the controller
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               load_regs;
  logic               add_regs;
  logic               shift_regs;
  logic               decr_pointer;

  // Status and result, driven by the datapath
  logic               Q0;
  logic               zero;
  logic [2*WIDTH-1:0] product;
  logic               done;
  logic               protocol_err;

  modport master (
    output multiplicand, multiplier, load_regs, add_regs, shift_regs, decr_pointer,
    input  Q0, zero, product, done, protocol_err
  );

  modport slave (
    input  multiplicand, multiplier, load_regs, add_regs, shift_regs, decr_pointer,
    output Q0, zero, product, done, protocol_err
  );
endinterface

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - shift-add unsigned multiplier datapath with iteration counter
module multiplier_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  multiplier_datapath_if.slave  bus
);

  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    p_q, p_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next-state: load wins outright; add beats shift; decrement runs alongside either
  always_comb begin
    b_d    = b_q;
    a_d    = a_q;
    c_d    = c_q;
    q_d    = q_q;
    p_d    = p_q;
    done_d = done_q;
    err_d  = err_q;

    if (bus.load_regs) begin
      b_d    = bus.multiplicand;
      q_d    = bus.multiplier;
      a_d    = '0;
      c_d    = 1'b0;
      p_d    = PW'(WIDTH);
      done_d = 1'b0;
    end else begin
      if (bus.add_regs) begin
        {c_d, a_d} = {1'b0, a_q} + {1'b0, b_q};
        // A shift requested alongside an add is dropped and flagged
        if (bus.shift_regs) begin
          err_d = 1'b1;
        end
      end else if (bus.shift_regs) begin
        {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
        // Shifting with the counter already at zero is the last iteration
        if (p_q == '0) begin
          done_d = 1'b1;
        end
      end

      if (bus.decr_pointer) begin
        if (p_q == '0) begin
          err_d = 1'b1;
        end else begin
          p_d = p_q - PW'(1);
        end
      end
    end
  end

  // State register with synchronous reset taking priority over every command
  always_ff @(posedge clk) begin
    if (reset) begin
      b_q    <= '0;
      a_q    <= '0;
      c_q    <= 1'b0;
      q_q    <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      b_q    <= b_d;
      a_q    <= a_d;
      c_q    <= c_d;
      q_q    <= q_d;
      p_q    <= p_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign bus.Q0           = q_q[0];
  assign bus.zero         = (p_q == '0);
  assign bus.product      = {a_q, q_q};
  assign bus.done         = done_q;
  assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - directed scoreboard bench for multiplier_datapath
module tb_multiplier_datapath;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic saw_q0;
  logic [2*WIDTH-1:0] exp_q[$];
  logic [2*WIDTH-1:0] exp_v;

  multiplier_datapath_if #(.WIDTH(WIDTH)) bus ();

  multiplier_datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock with the given command pulse; outputs are settled 1 time unit after the edge
  task automatic cmd(input logic l, input logic a, input logic s, input logic d);
    bus.load_regs    = l;
    bus.add_regs     = a;
    bus.shift_regs   = s;
    bus.decr_pointer = d;
    @(posedge clk);
    #1;
    bus.load_regs    = 1'b0;
    bus.add_regs     = 1'b0;
    bus.shift_regs   = 1'b0;
    bus.decr_pointer = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd(1'b0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic load(input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] mp);
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    exp_q.push_back((2*WIDTH)'(mc) * (2*WIDTH)'(mp));
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // In-order controller: decrement with conditional add, then shift
  task automatic iterate(input int n);
    for (int i = 0; i < n; i++) begin
      if (bus.Q0) saw_q0 = 1'b1;
      cmd(1'b0, bus.Q0, 1'b0, 1'b1);
      cmd(1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  // Wait a bounded number of cycles for done, then pop the scoreboard
  task automatic finish_run(input string tag);
    for (int k = 0; k < 4 && bus.done !== 1'b1; k++) cmd(1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_done"}, bus.done, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      exp_v = exp_q.pop_front();
      check({tag, "_product"}, bus.product, exp_v);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    saw_q0           = 1'b0;
    reset            = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.load_regs    = 1'b0;
    bus.add_regs     = 1'b0;
    bus.shift_regs   = 1'b0;
    bus.decr_pointer = 1'b0;
    #2;

    // Reset state
    do_reset();
    check("rst_product", bus.product, 0);
    check("rst_zero", bus.zero, 1);
    check("rst_q0", bus.Q0, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.protocol_err, 0);

    // 23 x 19
    load(8'd23, 8'd19);
    check("ld_product", bus.product, 16'h0013);
    check("ld_zero", bus.zero, 0);
    check("ld_q0", bus.Q0, 1);
    iterate(WIDTH);
    finish_run("m23x19");
    check("m23x19_exact", bus.product, 16'h01B5);
    check("m23x19_err", bus.protocol_err, 0);
    check("m23x19_zero", bus.zero, 1);
    cmd(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_done", bus.done, 1);
    check("hold_product", bus.product, 16'h01B5);

    // 255 x 255 exercises the carry into A
    load(8'd255, 8'd255);
    check("ld_clears_done", bus.done, 0);
    iterate(WIDTH);
    finish_run("m255x255");
    check("m255x255_exact", bus.product, 16'hFE01);

    // 200 x 0: no adds ever requested
    saw_q0 = 1'b0;
    load(8'd200, 8'd0);
    iterate(WIDTH);
    finish_run("m200x0");
    check("m200x0_no_q0", saw_q0, 0);

    // Abort mid-run with reset, then rerun
    load(8'd23, 8'd19);
    iterate(3);
    check("partial_not_done", bus.done, 0);
    do_reset();
    check("abort_product", bus.product, 0);
    check("abort_zero", bus.zero, 1);
    check("abort_done", bus.done, 0);
    load(8'd23, 8'd19);
    iterate(WIDTH);
    finish_run("rerun");

    // add + shift together: add only, sticky error through load
    load(8'd5, 8'd3);
    cmd(1'b0, 1'b1, 1'b1, 1'b0);
    check("addshift_product", bus.product, 16'h0503);
    check("addshift_err", bus.protocol_err, 1);
    load(8'd7, 8'd2);
    check("err_sticky_load", bus.protocol_err, 1);
    check("reload_product", bus.product, 16'h0002);
    exp_q.delete();

    // Decrement at zero: pointer holds, error raised
    do_reset();
    check("rst_clears_err", bus.protocol_err, 0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("decr0_zero", bus.zero, 1);
    check("decr0_err", bus.protocol_err, 1);
    cmd(1'b0, 1'b0, 1'b0, 1'b0);
    check("decr0_zero_hold", bus.zero, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
